// File: rtl/tx_symbol_mux.sv
// tx_symbol_mux: multi-lane TX symbol multiplexer with registered output,
// valid/ready handshake and a SKP ordered-set scheduler (COM + SKP_LEN x SKP).

// Per-lane combinational symbol selector. Illegal codes fall back to IDLE
// fill with dv=1 and raise err_o so the top can pulse ctl_err.
module tx_symbol_lane #(
  parameter logic [7:0] K_COM    = 8'hBC,
  parameter logic [7:0] K_SKP    = 8'h1C,
  parameter logic [7:0] K_STP    = 8'hFB,
  parameter logic [7:0] K_SDP    = 8'h5C,
  parameter logic [7:0] K_END    = 8'hFD,
  parameter logic [7:0] K_EDB    = 8'hFE,
  parameter logic [7:0] K_FTS    = 8'h3C,
  parameter logic [7:0] IDLE_SYM = 8'h00
) (
  input  logic       acc_i,
  input  logic [7:0] data_i,
  input  logic [3:0] ctl_i,
  output logic [7:0] sym_o,
  output logic       dv_o,
  output logic       err_o
);

  // Select data or control symbol; no accepted beat means IDLE fill.
  always_comb begin
    sym_o = IDLE_SYM;
    dv_o  = 1'b1;
    err_o = 1'b0;
    if (acc_i) begin
      case (ctl_i)
        4'd0: sym_o = data_i;
        4'd1: begin sym_o = K_COM; dv_o = 1'b0; end
        4'd2: begin sym_o = K_SKP; dv_o = 1'b0; end
        4'd3: begin sym_o = K_STP; dv_o = 1'b0; end
        4'd4: begin sym_o = K_SDP; dv_o = 1'b0; end
        4'd5: begin sym_o = K_END; dv_o = 1'b0; end
        4'd6: begin sym_o = K_EDB; dv_o = 1'b0; end
        4'd7: begin sym_o = K_FTS; dv_o = 1'b0; end
        4'd8: sym_o = IDLE_SYM;
        default: err_o = 1'b1;
      endcase
    end
  end

endmodule

module tx_symbol_mux #(
  parameter int         LANES        = 4,
  parameter int         SKP_INTERVAL = 32,
  parameter int         SKP_LEN      = 3,
  parameter logic [7:0] K_COM        = 8'hBC,
  parameter logic [7:0] K_SKP        = 8'h1C,
  parameter logic [7:0] K_STP        = 8'hFB,
  parameter logic [7:0] K_SDP        = 8'h5C,
  parameter logic [7:0] K_END        = 8'hFD,
  parameter logic [7:0] K_EDB        = 8'hFE,
  parameter logic [7:0] K_FTS        = 8'h3C,
  parameter logic [7:0] IDLE_SYM     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic [8*LANES-1:0]   tx_data,
  input  logic [4*LANES-1:0]   tx_ctl,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 skp_req,
  output logic [8*LANES-1:0]   tx_out,
  output logic [LANES-1:0]     tx_dv,
  output logic                 out_valid,
  output logic                 ctl_err
);

  localparam int CW = $clog2(SKP_INTERVAL);
  localparam int IW = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;
  localparam logic [CW-1:0] CYC_MAX = CW'(SKP_INTERVAL - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(SKP_LEN - 1);

  typedef enum logic [1:0] {S_RUN, S_COM, S_SKP} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cyc_q, cyc_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [LANES-1:0][7:0]      out_q, out_d;
  logic [LANES-1:0]           dv_q, dv_d;
  logic                       ov_q, ov_d;
  logic                       err_q, err_d;

  logic [LANES-1:0][7:0]      data_pk;
  logic [LANES-1:0][3:0]      ctl_pk;
  logic [LANES-1:0][7:0]      lane_sym;
  logic [LANES-1:0]           lane_dv;
  logic [LANES-1:0]           lane_err;
  logic                       acc;

  assign data_pk  = tx_data;
  assign ctl_pk   = tx_ctl;
  assign in_ready = enb && (state_q == S_RUN);
  assign acc      = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tx_symbol_lane #(
      .K_COM(K_COM), .K_SKP(K_SKP), .K_STP(K_STP), .K_SDP(K_SDP),
      .K_END(K_END), .K_EDB(K_EDB), .K_FTS(K_FTS), .IDLE_SYM(IDLE_SYM)
    ) u_lane (
      .acc_i  (acc),
      .data_i (data_pk[i]),
      .ctl_i  (ctl_pk[i]),
      .sym_o  (lane_sym[i]),
      .dv_o   (lane_dv[i]),
      .err_o  (lane_err[i])
    );
  end

  // Scheduler next state and next registered beat; disabled cycles emit
  // IDLE with out_valid low and freeze every counter.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    idx_d   = idx_q;
    out_d   = {LANES{IDLE_SYM}};
    dv_d    = '1;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    if (enb) begin
      ov_d = 1'b1;
      case (state_q)
        S_RUN: begin
          out_d = lane_sym;
          dv_d  = lane_dv;
          err_d = |lane_err;
          // expiry and request together still yield a single ordered set
          if (cyc_q == CYC_MAX || skp_req) begin
            cyc_d   = '0;
            state_d = S_COM;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        S_COM: begin
          out_d   = {LANES{K_COM}};
          dv_d    = '0;
          idx_d   = '0;
          state_d = S_SKP;
        end
        S_SKP: begin
          out_d = {LANES{K_SKP}};
          dv_d  = '0;
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = S_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and output registers; reset drops any partial ordered set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cyc_q   <= '0;
      idx_q   <= '0;
      out_q   <= {LANES{IDLE_SYM}};
      dv_q    <= '1;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end

  assign tx_out    = out_q;
  assign tx_dv     = dv_q;
  assign out_valid = ov_q;
  assign ctl_err   = err_q;

endmodule

// File: tb/tb_tx_symbol_mux.sv
// Randomized bench for tx_symbol_mux with a cycle-level behavioural model
// plus directed scenarios pinned by hand-computed literals.
module tb_tx_symbol_mux;

  localparam int LANES = 4;
  localparam int SKP_INTERVAL = 4;
  localparam int SKP_LEN = 3;

  logic                 clk, rst, enb, in_valid, in_ready, skp_req, out_valid, ctl_err;
  logic [8*LANES-1:0]   tx_data, tx_out;
  logic [4*LANES-1:0]   tx_ctl;
  logic [LANES-1:0]     tx_dv;

  tx_symbol_mux #(.LANES(LANES), .SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)) dut (
    .clk(clk), .rst(rst), .enb(enb), .tx_data(tx_data), .tx_ctl(tx_ctl),
    .in_valid(in_valid), .in_ready(in_ready), .skp_req(skp_req),
    .tx_out(tx_out), .tx_dv(tx_dv), .out_valid(out_valid), .ctl_err(ctl_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  logic rdy_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the ordered set (0 = COM, 1..SKP_LEN = SKP)
  // and number of RUN beats since the last set.
  int   m_run, m_pos;
  bit   m_os;
  logic [31:0] e_out;
  logic [3:0]  e_dv;
  logic        e_ov, e_err;
  logic [7:0]  ktab [0:7];

  initial begin
    ktab[0] = 8'h00; ktab[1] = 8'hBC; ktab[2] = 8'h1C; ktab[3] = 8'hFB;
    ktab[4] = 8'h5C; ktab[5] = 8'hFD; ktab[6] = 8'hFE; ktab[7] = 8'h3C;
  end

  function automatic void m_reset();
    m_run = 0; m_pos = 0; m_os = 0;
    e_out = '0; e_dv = '1; e_ov = 0; e_err = 0;
  endfunction

  function automatic void m_step();
    int c;
    e_err = 0;
    if (!enb) begin
      e_out = '0; e_dv = '1; e_ov = 0;
      return;
    end
    e_ov = 1;
    if (!m_os) begin
      for (int i = 0; i < LANES; i++) begin
        c = int'(tx_ctl[4*i +: 4]);
        e_out[8*i +: 8] = 8'h00;
        e_dv[i] = 1'b1;
        if (in_valid) begin
          if (c == 0) e_out[8*i +: 8] = tx_data[8*i +: 8];
          else if (c <= 7) begin e_out[8*i +: 8] = ktab[c]; e_dv[i] = 1'b0; end
          else if (c > 8) e_err = 1;
        end
      end
      m_run++;
      if (m_run == SKP_INTERVAL || skp_req) begin
        m_os = 1; m_pos = 0; m_run = 0;
      end
    end else begin
      e_out = (m_pos == 0) ? 32'hBCBCBCBC : 32'h1C1C1C1C;
      e_dv  = '0;
      m_pos++;
      if (m_pos > SKP_LEN) m_os = 0;
    end
  endfunction

  // Compare DUT against model every cycle, mid-period.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_out", 64'(tx_out), 64'(e_out));
      chk("tx_dv", 64'(tx_dv), 64'(e_dv));
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("ctl_err", 64'(ctl_err), 64'(e_err));
      chk("in_ready", 64'(in_ready), 64'(enb && !m_os));
    end
  end

  // One clock cycle; called at posedge+2, returns at next posedge+2.
  task automatic cyc(input logic e, input logic v, input logic [31:0] d,
                     input logic [15:0] c, input logic r);
    enb = e; in_valid = v; tx_data = d; tx_ctl = c; skp_req = r;
    #1 rdy_s = in_ready;
    @(posedge clk);
    m_step();
    #2;
  endtask

  // Asynchronous reset asserted mid-cycle, spanning one clock edge.
  task automatic do_reset();
    enb = 0; in_valid = 0; skp_req = 0;
    #1 rst = 1;
    #1 chk("reset_async", 64'({tx_out, tx_dv, out_valid, ctl_err}), 64'({32'h0, 4'hF, 2'b00}));
    m_reset();
    @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic run_rec(input int n, input logic [31:0] req_m, input logic [31:0] enb_m,
                         output logic [31:0] com_m, output logic [31:0] skp_m,
                         output logic [31:0] ov_m, output logic [31:0] rdy_m);
    com_m = '0; skp_m = '0; ov_m = '0; rdy_m = '0;
    for (int k = 0; k < n; k++) begin
      cyc(enb_m[k], 1'b1, $urandom, 16'h0000, req_m[k]);
      rdy_m[k] = rdy_s;
      ov_m[k]  = out_valid;
      com_m[k] = out_valid && tx_dv == 4'h0 && tx_out == 32'hBCBCBCBC;
      skp_m[k] = out_valid && tx_dv == 4'h0 && tx_out == 32'h1C1C1C1C;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] cm, sm, om, rm;
    logic [15:0] c;
    rst = 0; enb = 0; in_valid = 0; skp_req = 0; tx_data = '0; tx_ctl = '0;
    #1 rst = 1;
    #1 chk("reset_init", 64'({tx_out, tx_dv, out_valid, ctl_err}), 64'({32'h0, 4'hF, 2'b00}));
    m_reset();
    chk_en = 1;
    @(posedge clk);
    #2 rst = 0;

    // IDLE fill after release
    cyc(1, 0, 32'hDEADBEEF, 16'h0000, 0);
    chk("idle_fill", 64'({tx_out, tx_dv, out_valid}), 64'({32'h0, 4'hF, 1'b1}));
    cyc(1, 0, 32'h0, 16'h0000, 0);

    // lane mux: ctl {0,1,5,8}
    cyc(1, 1, 32'hA1B2C3D4, 16'h8510, 0);
    chk("mux_out", 64'(tx_out), 64'(32'h00FDBCD4));
    chk("mux_dv", 64'(tx_dv), 64'(4'b1001));

    // cadence: 4 data, COM, 3 SKP, period 8
    do_reset();
    run_rec(16, 32'h0, 32'hFFFFFFFF, cm, sm, om, rm);
    chk("cad_com", 64'(cm[15:0]), 64'(16'h1010));
    chk("cad_skp", 64'(sm[15:0]), 64'(16'hE0E0));
    chk("cad_rdy", 64'(rm[15:0]), 64'(16'h0F0F));

    // skp_req at cyc_cnt=1, ignored during SKP, coincident with expiry
    do_reset();
    run_rec(20, 32'h0000020A, 32'hFFFFFFFF, cm, sm, om, rm);
    chk("req_com", 64'(cm[19:0]), 64'(20'h40404));
    chk("req_skp", 64'(sm[19:0]), 64'(20'h83838));

    // enb=0 over the second SKP, resume with the remaining two
    do_reset();
    run_rec(16, 32'h0, 32'h0000FE3F, cm, sm, om, rm);
    chk("enb_com", 64'(cm[15:0]), 64'(16'h8010));
    chk("enb_skp", 64'(sm[15:0]), 64'(16'h0620));
    chk("enb_ov", 64'(om[15:0]), 64'(16'hFE3F));

    // reset while in COM: full interval before the next ordered set
    do_reset();
    run_rec(4, 32'h0, 32'hFFFFFFFF, cm, sm, om, rm);
    do_reset();
    run_rec(16, 32'h0, 32'hFFFFFFFF, cm, sm, om, rm);
    chk("rstcom_com", 64'(cm[15:0]), 64'(16'h1010));

    // illegal code 4'hC on lane 2
    cyc(1, 1, 32'h11223344, 16'h0C30, 0);
    chk("ill_out", 64'(tx_out), 64'(32'h1100FB44));
    chk("ill_dv", 64'(tx_dv), 64'(4'b1101));
    chk("ill_err", 64'(ctl_err), 64'(1'b1));
    cyc(1, 1, 32'h55667788, 16'h0000, 0);
    chk("ill_err_clr", 64'(ctl_err), 64'(1'b0));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      for (int i = 0; i < LANES; i++)
        c[4*i +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                  : 4'($urandom_range(0, 8));
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom, c,
          $urandom_range(0, 15) == 0);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
